// File: rtl/dram_responder_if.sv
// Per-core DRAM request/response bundle between the core instances and dram_responder.
// Core k occupies slice k of every packed field.
interface dram_responder_if #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 16
);
    logic [N_CORES*ADDR_W-1:0] i_dram_addr;
    logic [N_CORES*2-1:0]      i_dram_read;
    logic [N_CORES*2-1:0]      i_dram_write;
    logic [N_CORES*8-1:0]      i_dram_wdata;
    logic [N_CORES*8-1:0]      o_dram_rdata;
    logic [N_CORES-1:0]        o_ack;
    logic                      o_err;
    logic                      o_busy;

    modport master (
        output i_dram_addr, i_dram_read, i_dram_write, i_dram_wdata,
        input  o_dram_rdata, o_ack, o_err, o_busy
    );

    modport slave (
        input  i_dram_addr, i_dram_read, i_dram_write, i_dram_wdata,
        output o_dram_rdata, o_ack, o_err, o_busy
    );
endinterface

// File: rtl/dram_responder.sv
// Shared byte-wide data memory serving N_CORES initiators, one access per three cycles.
// Define DRAM_RESPONDER_RR_ARB_EN for round-robin arbitration; fixed lowest-index priority otherwise.
//
// state  | meaning
// IDLE   | sample masked requests, latch the winner's address/data/op
// ACCESS | perform the array write or the registered read
// RESP   | pulse ack (and err) to the winner, arm the ack mask
module dram_responder #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 4096
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    dram_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int G_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [G_W-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 wr_q, wr_d;
    logic                 in_range_q, in_range_d;
    logic                 err_q, err_d;
    logic [N_CORES-1:0]   mask_q, mask_d;
    logic [N_CORES*8-1:0] rdata_q, rdata_d;

    logic [7:0] mem [DEPTH];

    logic [N_CORES-1:0] req_rd, req_wr, req_m;
    logic [N_CORES-1:0] gnt_oh;
    logic               found;
    logic [G_W-1:0]     win;
    logic [ADDR_W-1:0]  win_addr;
    logic [7:0]         win_wdata;
    logic               win_rd, win_wr;
    logic [7:0]         rd_byte;

    always_comb begin : decode
        for (int k = 0; k < N_CORES; k++) begin
            req_rd[k] = (bus.i_dram_read[k*2 +: 2] == 2'b01);
            req_wr[k] = (bus.i_dram_write[k*2 +: 2] == 2'b01);
        end
        req_m = (req_rd | req_wr) & ~mask_q;
    end

    always_comb begin : grant_onehot
        for (int k = 0; k < N_CORES; k++) begin
            gnt_oh[k] = (G_W'(k) == gnt_q);
        end
    end

`ifdef DRAM_RESPONDER_RR_ARB_EN
    logic [G_W-1:0] ptr_q, ptr_d;

    // Search starts at the pointer and wraps; first requester found wins.
    always_comb begin : arb_rr
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N_CORES; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_CORES) begin
                idx = idx - N_CORES;
            end
            for (int k = 0; k < N_CORES; k++) begin
                if (!found && (k == idx) && req_m[k]) begin
                    found = 1'b1;
                    win   = G_W'(k);
                end
            end
        end
    end

    always_comb begin : ptr_next
        ptr_d = ptr_q;
        if (state_q == RESP) begin
            ptr_d = (gnt_q == G_W'(N_CORES - 1)) ? '0 : gnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin : arb_fixed
        found = 1'b0;
        win   = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            if (req_m[k]) begin
                found = 1'b1;
                win   = G_W'(k);
            end
        end
    end
`endif

    always_comb begin : winner_fields
        win_addr  = '0;
        win_wdata = '0;
        win_rd    = 1'b0;
        win_wr    = 1'b0;
        for (int k = 0; k < N_CORES; k++) begin
            if (G_W'(k) == win) begin
                win_addr  = bus.i_dram_addr[k*ADDR_W +: ADDR_W];
                win_wdata = bus.i_dram_wdata[k*8 +: 8];
                win_rd    = req_rd[k];
                win_wr    = req_wr[k];
            end
        end
    end

    // Out-of-range reads return zero rather than an aliased location.
    assign rd_byte = in_range_q ? mem[idx_q] : 8'h00;

    always_comb begin : fsm
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        in_range_d = in_range_q;
        err_d      = err_q;
        mask_d     = '0;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = win;
                    idx_d      = win_addr[IDX_W-1:0];
                    wdata_d    = win_wdata;
                    wr_d       = win_wr;
                    in_range_d = ({1'b0, win_addr} < DEPTH_X);
                    err_d      = (win_rd && win_wr) || !in_range_d;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (!wr_q) begin
                    for (int k = 0; k < N_CORES; k++) begin
                        if (G_W'(k) == gnt_q) begin
                            rdata_d[k*8 +: 8] = rd_byte;
                        end
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                mask_d  = gnt_oh;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            in_range_q <= 1'b0;
            err_q      <= 1'b0;
            mask_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            in_range_q <= in_range_d;
            err_q      <= err_d;
            mask_q     <= mask_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage survives reset; a write caught by reset in ACCESS is abandoned.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && (state_q == ACCESS) && wr_q && in_range_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.o_dram_rdata = rdata_q;
    assign bus.o_ack        = (state_q == RESP) ? gnt_oh : '0;
    assign bus.o_err        = (state_q == RESP) && err_q;
    assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder: directed transactions push expected acks,
// a negedge monitor pops and compares whenever an ack appears.
module tb_dram_responder;
    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int DEPTH = 4096;
    localparam logic [1:0] RQ = 2'b01;
    localparam logic [1:0] NO = 2'b00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_responder_if #(.N_CORES(N), .ADDR_W(AW)) bus ();

    dram_responder #(.N_CORES(N), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int         core;
        bit         is_rd;
        logic [7:0] data;
        bit         err;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] model_rd [N];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         lat;
    int         acks;
    bit         rereq;
    bit         rereq_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*8-1:0] model_vec();
        logic [N*8-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*8 +: 8] = model_rd[k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_ack != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(bus.o_ack), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_core", 32'(bus.o_ack), 32'd1 << mon_e.core);
                    check("ack_err", 32'(bus.o_err), 32'(mon_e.err));
                    if (mon_e.is_rd) model_rd[mon_e.core] = mon_e.data;
                    check("rdata_vec", bus.o_dram_rdata, model_vec());
                end
            end else if (bus.o_err) begin
                check("err_without_ack", 32'(bus.o_err), 32'd0);
            end
        end
    end

    task automatic set_req(input int c, input logic [1:0] rd, input logic [1:0] wr,
                           input logic [15:0] a, input logic [7:0] d);
        bus.i_dram_read[c*2 +: 2]    = rd;
        bus.i_dram_write[c*2 +: 2]   = wr;
        bus.i_dram_addr[c*AW +: AW]  = a;
        bus.i_dram_wdata[c*8 +: 8]   = d;
    endtask

    task automatic push(input int c, input bit is_rd, input logic [7:0] d, input bit err);
        exp_t e;
        e.core  = c;
        e.is_rd = is_rd;
        e.data  = d;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int c, output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!bus.o_ack[c] && l < 12);
    endtask

    task automatic txn(input int c, input logic [1:0] rd, input logic [1:0] wr,
                       input logic [15:0] a, input logic [7:0] d,
                       input bit is_rd, input logic [7:0] exp_d, input bit exp_err);
        int l;
        repeat (2) @(negedge clk);
        push(c, is_rd, exp_d, exp_err);
        set_req(c, rd, wr, a, d);
        wait_ack(c, l);
        check("ack_latency", l, 2);
        set_req(c, NO, NO, 16'h0, 8'h0);
    endtask

    task automatic wr_txn(input int c, input logic [15:0] a, input logic [7:0] d, input bit err);
        txn(c, NO, RQ, a, d, 1'b0, 8'h00, err);
    endtask

    task automatic rd_txn(input int c, input logic [15:0] a, input logic [7:0] exp_d, input bit err);
        txn(c, RQ, NO, a, 8'h00, 1'b1, exp_d, err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_dram_addr  = '0;
        bus.i_dram_read  = '0;
        bus.i_dram_write = '0;
        bus.i_dram_wdata = '0;
        foreach (model_rd[k]) model_rd[k] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_ack", 32'(bus.o_ack), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        check("rst_rdata", bus.o_dram_rdata, 32'd0);
        rst_n = 1'b1;

        // basic write then read-back by core 1
        wr_txn(1, 16'h0010, 8'hA5, 1'b0);
        rd_txn(1, 16'h0010, 8'hA5, 1'b0);
        check("t1_rdata1", 32'(bus.o_dram_rdata[15:8]), 32'hA5);

        // range boundary: 0x0FFF last valid, 0x1000 first invalid, no wrap-around
        wr_txn(0, 16'h0FFF, 8'h77, 1'b0);
        rd_txn(0, 16'h0FFF, 8'h77, 1'b0);
        rd_txn(0, 16'h1000, 8'h00, 1'b1);
        wr_txn(0, 16'hFFFF, 8'h55, 1'b1);
        wr_txn(0, 16'h1010, 8'hEE, 1'b1);
        rd_txn(0, 16'h0FFF, 8'h77, 1'b0);

        // read/write conflict: write wins, reader's data untouched
        rd_txn(2, 16'h0010, 8'hA5, 1'b0);
        txn(2, RQ, RQ, 16'h0020, 8'h3C, 1'b0, 8'h00, 1'b1);
        check("conflict_rdata_hold", 32'(bus.o_dram_rdata[23:16]), 32'hA5);
        rd_txn(0, 16'h0020, 8'h3C, 1'b0);

        // codes 10 and 11 are not requests
        repeat (2) @(negedge clk);
        set_req(1, 2'b11, 2'b10, 16'h0010, 8'h00);
        repeat (6) @(negedge clk);
        set_req(1, 2'b10, 2'b11, 16'h0010, 8'h00);
        repeat (6) @(negedge clk);
        check("noreq_busy", 32'(bus.o_busy), 32'd0);
        set_req(1, NO, NO, 16'h0, 8'h0);

        // reset while core 1's read is in ACCESS: abandoned, no ack
        repeat (2) @(negedge clk);
        set_req(1, RQ, NO, 16'h0010, 8'h00);
        @(negedge clk);
        check("access_busy", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        set_req(1, NO, NO, 16'h0, 8'h0);
        @(negedge clk);
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_ack", 32'(bus.o_ack), 32'd0);
        check("abort_rdata", bus.o_dram_rdata, 32'd0);
        foreach (model_rd[k]) model_rd[k] = 8'h00;
        rst_n = 1'b1;

        // contention from pointer 0: cores 0, 2, 3 held; core 0 re-requests after its ack
        repeat (2) @(negedge clk);
`ifdef DRAM_RESPONDER_RR_ARB_EN
        push(0, 1'b1, 8'hA5, 1'b0);
        push(2, 1'b1, 8'h3C, 1'b0);
        push(3, 1'b0, 8'h00, 1'b0);
        push(0, 1'b1, 8'h77, 1'b0);
`else
        push(0, 1'b1, 8'hA5, 1'b0);
        push(2, 1'b1, 8'h3C, 1'b0);
        push(0, 1'b1, 8'h77, 1'b0);
        push(3, 1'b0, 8'h00, 1'b0);
`endif
        set_req(0, RQ, NO, 16'h0010, 8'h00);
        set_req(2, RQ, NO, 16'h0020, 8'h00);
        set_req(3, NO, RQ, 16'h0030, 8'h99);
        acks       = 0;
        rereq      = 1'b0;
        rereq_done = 1'b0;
        for (int t = 0; t < 40 && acks < 4; t++) begin
            @(negedge clk);
            if (rereq) begin
                set_req(0, RQ, NO, 16'h0FFF, 8'h00);
                rereq      = 1'b0;
                rereq_done = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                if (bus.o_ack[k]) begin
                    acks++;
                    set_req(k, NO, NO, 16'h0, 8'h0);
                    if (k == 0 && !rereq_done) rereq = 1'b1;
                end
            end
        end
        check("multi_ack_count", acks, 4);

        // storage kept across reset
        rd_txn(1, 16'h0010, 8'hA5, 1'b0);
        rd_txn(3, 16'h0030, 8'h99, 1'b0);

        // ack mask: held two cycles past ack -> one ack; three cycles -> two acks
        repeat (2) @(negedge clk);
        push(3, 1'b1, 8'hA5, 1'b0);
        set_req(3, RQ, NO, 16'h0010, 8'h00);
        wait_ack(3, lat);
        check("mask_latency", lat, 2);
        repeat (2) @(negedge clk);
        set_req(3, NO, NO, 16'h0, 8'h0);
        repeat (6) @(negedge clk);
        check("mask_single_ack", sb.size(), 0);

        push(3, 1'b1, 8'hA5, 1'b0);
        push(3, 1'b1, 8'hA5, 1'b0);
        set_req(3, RQ, NO, 16'h0010, 8'h00);
        wait_ack(3, lat);
        check("mask2_latency", lat, 2);
        repeat (3) @(negedge clk);
        set_req(3, NO, NO, 16'h0, 8'h0);
        repeat (6) @(negedge clk);
        check("mask_second_ack", sb.size(), 0);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
